// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and header helper for the UART TX arbiter
package uart_pkg;

    localparam logic [3:0] HDR_TAG                = 4'hA;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 50000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_HDR  = 3'd1,
        WAIT_HDR  = 3'd2,
        SEND_DATA = 3'd3,
        WAIT_DATA = 3'd4,
        ACK       = 3'd5
    } state_t;

    function automatic logic [7:0] header_byte(input logic [3:0] id);
        return {HDR_TAG, id};
    endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - round-robin pick of the first set request after last_grant
module rr_select #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [3:0]         last_grant,
    output logic               found,
    output logic [3:0]         index
);

    int                 pos;
    logic [NUM_REQ-1:0] rot;

    // Walk from farthest to nearest so the nearest hit after last_grant wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = 0;
        rot   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = (int'(last_grant) + 1 + k) % NUM_REQ;
            rot = request >> pos;
            if (rot[0]) begin
                found = 1'b1;
                index = 4'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter among requesters as 2-byte frames
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clock_50mhz,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [3:0]           grant_id,
    output logic                 active,
    output logic                 err_timeout
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, next_state;
    logic [3:0]  last_grant;
    logic [7:0]  payload;
    logic [7:0]  sel_data;
    logic [15:0] tmo_cnt;
    logic        sel_found;
    logic [3:0]  sel_index;
    logic        in_wait;
    logic        timeout_hit;

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .request    (req_valid),
        .last_grant (last_grant),
        .found      (sel_found),
        .index      (sel_index)
    );

    assign sel_data = 8'(req_data >> {sel_index, 3'b000});
    assign in_wait  = (state == WAIT_HDR) || (state == WAIT_DATA);
    // The counter would reach TIMEOUT_CYCLES on this increment; a coincident tx_done wins.
    assign timeout_hit = in_wait && !tx_done && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (sel_found) next_state = SEND_HDR;
            SEND_HDR:  if (!tx_busy) next_state = WAIT_HDR;
            WAIT_HDR:  if (tx_done) next_state = SEND_DATA;
                       else if (timeout_hit) next_state = IDLE;
            SEND_DATA: if (!tx_busy) next_state = WAIT_DATA;
            WAIT_DATA: if (tx_done) next_state = ACK;
                       else if (timeout_hit) next_state = IDLE;
            ACK:       next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        req_ack     = '0;
        err_timeout = timeout_hit;
        active      = (state != IDLE);
        case (state)
            SEND_HDR: if (!tx_busy) begin
                tx_start = 1'b1;
                tx_data  = header_byte(grant_id);
            end
            SEND_DATA: if (!tx_busy) begin
                tx_start = 1'b1;
                tx_data  = payload;
            end
            ACK:      req_ack = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
            default:  ;
        endcase
    end

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            grant_id   <= 4'd0;
            payload    <= 8'h00;
            last_grant <= 4'(NUM_REQ - 1);
            tmo_cnt    <= 16'd0;
        end else begin
            if (state == IDLE && sel_found) begin
                grant_id <= sel_index;
                payload  <= sel_data;
            end
            if (tx_start) begin
                tmo_cnt <= 16'd0;
            end else if (in_wait) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (state == ACK || timeout_hit) begin
                last_grant <= grant_id;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL use one clock, clock_50mhz; reset SHALL be synchronous and active-high on port reset.
REQ-002 Parameter NUM_REQ SHALL default to 4 (legal range 2..16) and set the number of requesters.
REQ-003 Parameter TIMEOUT_CYCLES SHALL default to 50000 (legal range 1..65535) and bound the wait for tx_done per byte.
REQ-004 Port clock_50mhz  in  1  system clock.
REQ-005 Port reset  in  1  synchronous active-high reset.
REQ-006 Port req_valid  in  NUM_REQ  per-requester send request; bit i belongs to requester i.
REQ-007 Port req_data  in  8*NUM_REQ  payload byte; requester i occupies bits [8i+7:8i].
REQ-008 Port req_ack  out  NUM_REQ  one-cycle pulse: requester i's frame was fully sent.
REQ-009 Port tx_start  out  1  one-cycle pulse launching one byte on the shared transmitter.
REQ-010 Port tx_data  out  8  byte to transmit; valid while tx_start=1.
REQ-011 Port tx_busy  in  1  shared transmitter busy.
REQ-012 Port tx_done  in  1  one-cycle pulse at the end of the transmitter's stop bit.
REQ-013 Port grant_id  out  4  index of the currently served requester.
REQ-014 Port active  out  1  high while a frame is in progress (any state except IDLE).
REQ-015 Port err_timeout  out  1  one-cycle pulse when a frame is aborted on timeout.

Function
REQ-016 Each granted request SHALL be sent as a 2-byte frame: header {4'hA, grant_id}, then the latched payload byte.
REQ-017 FSM states SHALL be IDLE, SEND_HDR, WAIT_HDR, SEND_DATA, WAIT_DATA, ACK.
REQ-018 IDLE: if any req_valid bit is 1, the FSM SHALL grant round-robin, starting the search at (last_grant+1) mod NUM_REQ, latch grant_id and that requester's req_data, and enter SEND_HDR on the next cycle.
REQ-019 SEND_HDR and SEND_DATA: while tx_busy=1 the FSM SHALL wait; when tx_busy=0 it SHALL pulse tx_start for exactly one cycle with the corresponding byte and move to WAIT_HDR or WAIT_DATA respectively.
REQ-020 WAIT_HDR: tx_done=1 SHALL move to SEND_DATA. WAIT_DATA: tx_done=1 SHALL move to ACK.
REQ-021 ACK SHALL last one cycle, assert req_ack[grant_id] only, set last_grant=grant_id, and return to IDLE.
REQ-022 Payload and grant_id SHALL be latched at grant; changes on req_data or deassertion of req_valid after grant SHALL NOT affect the frame in progress.
REQ-023 A requester SHALL drop req_valid on the edge after seeing req_ack; a req_valid still high in IDLE SHALL be treated as a new request.
REQ-024 A 16-bit timeout counter SHALL clear on each tx_start and increment each cycle in WAIT_HDR and WAIT_DATA.
REQ-025 When the counter reaches TIMEOUT_CYCLES without tx_done, the FSM SHALL pulse err_timeout, give no req_ack, set last_grant=grant_id, and return to IDLE.
REQ-026 If tx_done arrives in the same cycle the timeout is reached, tx_done SHALL win and no error SHALL be raised.
REQ-027 tx_done outside WAIT_HDR and WAIT_DATA SHALL be ignored.
REQ-028 At most one tx_start SHALL be outstanding at any time; tx_start SHALL never assert while tx_busy=1.

Reset
REQ-029 On reset, the FSM SHALL enter IDLE and last_grant SHALL be NUM_REQ-1, so that requester 0 has first priority.
REQ-030 On reset, req_ack, tx_start, err_timeout and active SHALL be 0, and tx_data and grant_id SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no ack, no error pulse and no further tx_start.

Structure
REQ-032 The header tag 4'hA, the FSM state encoding and the default TIMEOUT_CYCLES SHALL live in the shared package uart_pkg.
REQ-033 The round-robin selector SHALL be one sub-module, rr_select: inputs request vector and last_grant; outputs found and index.

Verification
REQ-034 After reset, req_valid=4'b0001 with data 0x55 and an ideal transmitter -> tx_data 0xA0 then 0x55, followed by a single req_ack=4'b0001.
REQ-035 req_valid=4'b1111 held high, with requesters re-raising valid after each ack -> grant order 0,1,2,3,0.
REQ-036 tx_busy held at 1 for 100 cycles in SEND_HDR -> no tx_start until tx_busy=0, then exactly one pulse.
REQ-037 TIMEOUT_CYCLES=20 and tx_done never returned -> err_timeout pulse 20 cycles after tx_start, no req_ack, and the next grant goes to the following requester.
REQ-038 req_data changed from 0x11 to 0x22 and req_valid dropped during WAIT_HDR -> payload byte sent is 0x11 and req_ack still pulses.
REQ-039 Reset asserted in WAIT_DATA -> all outputs return to reset values on the next cycle and no req_ack is given.
